clk_monitor: RTL and testbench

CLK_MONITOR -- requirements
Module: clk_monitor

---
 rtl/clk_monitor_pkg.sv | 27 ++
 rtl/clk_monitor_chk.sv | 131 +++++++++++++
 rtl/clk_monitor.sv | 71 +++++++
 tb/tb_clk_monitor.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_monitor_pkg.sv
// -----------------------------------------------------------------------------
// clk_monitor_pkg
// Shared definitions for the divided-clock monitor:
//   - CNT_W / CNT_MAX : width and saturation value of the per-channel
//                       half-period counter
//   - chk_state_e     : per-channel monitor state (3-bit encoding)
//   - sat_inc()       : saturating increment used by the half-period counter
// -----------------------------------------------------------------------------
package clk_monitor_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAULT  = 3'd4
  } chk_state_e;

  // Counter sticks at CNT_MAX so a dead input can never wrap back onto HALF.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/clk_monitor_chk.sv
// -----------------------------------------------------------------------------
// clk_chk
// One monitor channel. Watches a divided clock that is generated in the clk
// domain and checks that every half-period lasts exactly HALF clk cycles.
// After one synchronising edge and LOCK_CNT consecutive good half-periods the
// channel reports lock; any bad half-period while locked latches a fault that
// only i_enb low or reset can clear.
//
// Ports:
//   clk     in  system clock, all logic on its rising edge
//   rst     in  asynchronous active-low reset
//   i_enb   in  monitor enable; low returns the channel to IDLE
//   i_div   in  divided clock under test (already in the clk domain)
//   o_lock  out channel is LOCKED
//   o_err   out channel is in FAULT (sticky)
// -----------------------------------------------------------------------------
module clk_chk
  import clk_monitor_pkg::*;
#(
  parameter int HALF     = 4,
  parameter int LOCK_CNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_enb,
  input  logic i_div,
  output logic o_lock,
  output logic o_err
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] HALF_C  = CNT_W'(HALF);
  localparam logic [GW-1:0]    LOCK_M1 = GW'(LOCK_CNT - 1);
  localparam logic [GW-1:0]    LOCK_C  = GW'(LOCK_CNT);

  logic             r_sq;
  logic [CNT_W-1:0] r_cnt;
  logic [GW-1:0]    r_good;
  logic [GW-1:0]    w_good_nxt;
  chk_state_e       r_state;
  chk_state_e       w_state_nxt;

  logic w_edge;
  logic w_at_half;
  logic w_good;
  logic w_bad;

  // Input is already clk-synchronous, so a single register is enough to see
  // transitions; no extra synchroniser stages.
  assign w_edge    = i_div ^ r_sq;
  assign w_at_half = (r_cnt == HALF_C);
  assign w_good    = w_edge & w_at_half;
  // Bad: an edge arriving early/late, or the expected edge missing at HALF.
  assign w_bad     = w_edge ^ w_at_half;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sq  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_sq  <= i_div;
      // Count restarts at 1 on the edge so that cnt == HALF on the next edge
      // of an ideal divider.
      r_cnt <= w_edge ? CNT_W'(1) : sat_inc(r_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_good  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_good  <= w_good_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    if (!i_enb) begin
      // Disable overrides any edge seen in the same cycle.
      w_state_nxt = ST_IDLE;
      w_good_nxt  = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_SYNC;
        end
        ST_SYNC: begin
          // Phase of the divider is unknown here, so timeouts are ignored and
          // the first edge just aligns the counter.
          if (w_edge) begin
            w_state_nxt = ST_CHECK;
            w_good_nxt  = '0;
          end
        end
        ST_CHECK: begin
          if (w_good) begin
            if (r_good == LOCK_M1) begin
              w_state_nxt = ST_LOCKED;
              w_good_nxt  = LOCK_C;
            end else begin
              w_good_nxt = r_good + GW'(1);
            end
          end else if (w_bad) begin
            w_state_nxt = ST_SYNC;
            w_good_nxt  = '0;
          end
        end
        ST_LOCKED: begin
          if (w_bad) begin
            w_state_nxt = ST_FAULT;
          end
        end
        ST_FAULT: begin
          w_state_nxt = ST_FAULT;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_good_nxt  = '0;
        end
      endcase
    end
  end

  // Flags decode straight from the state register: no combinational glitches.
  assign o_lock = (r_state == ST_LOCKED);
  assign o_err  = (r_state == ST_FAULT);

endmodule

// File: rtl/clk_monitor.sv
// -----------------------------------------------------------------------------
// clk_monitor
// Monitors three clk-domain divided clocks (clk10, clk20, clk40) for correct
// half-period length and reports per-channel lock and sticky fault flags.
// Channels are fully independent; all_lock is the AND of the three locks.
//
// Ports:
//   clk       in   system clock (rising edge)
//   rst       in   asynchronous active-low reset
//   enb       in   monitor enable; low forces every channel to IDLE
//   clk10     in   divided clock, expected half-period HALF10 clk cycles
//   clk20     in   divided clock, expected half-period HALF20 clk cycles
//   clk40     in   divided clock, expected half-period HALF40 clk cycles
//   lock[2:0] out  locked flags, bit0=clk10 bit1=clk20 bit2=clk40
//   err[2:0]  out  sticky fault flags, same bit order
//   all_lock  out  all three channels locked
// -----------------------------------------------------------------------------
module clk_monitor
  import clk_monitor_pkg::*;
#(
  parameter int HALF10   = 4,
  parameter int HALF20   = 2,
  parameter int HALF40   = 1,
  parameter int LOCK_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       clk10,
  input  logic       clk20,
  input  logic       clk40,
  output logic [2:0] lock,
  output logic [2:0] err,
  output logic       all_lock
);

  logic [2:0] w_lock;
  logic [2:0] w_err;

  clk_chk #(.HALF(HALF10), .LOCK_CNT(LOCK_CNT)) u_chk10 (
    .clk    (clk),
    .rst    (rst),
    .i_enb  (enb),
    .i_div  (clk10),
    .o_lock (w_lock[0]),
    .o_err  (w_err[0])
  );

  clk_chk #(.HALF(HALF20), .LOCK_CNT(LOCK_CNT)) u_chk20 (
    .clk    (clk),
    .rst    (rst),
    .i_enb  (enb),
    .i_div  (clk20),
    .o_lock (w_lock[1]),
    .o_err  (w_err[1])
  );

  clk_chk #(.HALF(HALF40), .LOCK_CNT(LOCK_CNT)) u_chk40 (
    .clk    (clk),
    .rst    (rst),
    .i_enb  (enb),
    .i_div  (clk40),
    .o_lock (w_lock[2]),
    .o_err  (w_err[2])
  );

  assign lock     = w_lock;
  assign err      = w_err;
  assign all_lock = &w_lock;

endmodule

// File: tb/tb_clk_monitor.sv
module tb_clk_monitor;

  localparam int H10 = 4;
  localparam int H20 = 2;
  localparam int H40 = 1;
  localparam int LCK = 4;

  localparam int M_IDLE   = 0;
  localparam int M_SYNC   = 1;
  localparam int M_CHECK  = 2;
  localparam int M_LOCKED = 3;
  localparam int M_FAULT  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enb = 1'b0;
  logic       clk10 = 1'b0;
  logic       clk20 = 1'b0;
  logic       clk40 = 1'b0;
  logic [2:0] lock;
  logic [2:0] err;
  logic       all_lock;

  always #5 clk = ~clk;

  clk_monitor #(
    .HALF10(H10), .HALF20(H20), .HALF40(H40), .LOCK_CNT(LCK)
  ) dut (
    .clk(clk), .rst(rst), .enb(enb),
    .clk10(clk10), .clk20(clk20), .clk40(clk40),
    .lock(lock), .err(err), .all_lock(all_lock)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each channel is tracked by the cycle number of its last input transition;
  // the half-period so far is simply "now - last transition".
  int   half_of[3] = '{H10, H20, H40};
  int   m_mode[3];
  int   m_good[3];
  int   m_last[3];
  logic [2:0] m_prev;
  int   m_n;

  function automatic void model_reset();
    for (int ch = 0; ch < 3; ch++) begin
      m_mode[ch] = M_IDLE;
      m_good[ch] = 0;
      m_last[ch] = 0;
    end
    m_prev = 3'b000;
    m_n    = 0;
  endfunction

  function automatic void model_step(input bit e, input logic [2:0] v);
    for (int ch = 0; ch < 3; ch++) begin
      int since;
      bit ed, on_time, ok, ko;
      since = m_n - m_last[ch];
      if (since > 255) since = 255;
      ed      = (v[ch] != m_prev[ch]);
      on_time = (since == half_of[ch]);
      ok      = ed && on_time;
      ko      = (ed && !on_time) || (!ed && on_time);
      if (!e) begin
        m_mode[ch] = M_IDLE;
        m_good[ch] = 0;
      end else if (m_mode[ch] == M_IDLE) begin
        m_mode[ch] = M_SYNC;
      end else if (m_mode[ch] == M_SYNC) begin
        if (ed) begin
          m_mode[ch] = M_CHECK;
          m_good[ch] = 0;
        end
      end else if (m_mode[ch] == M_CHECK) begin
        if (ok) begin
          m_good[ch] = m_good[ch] + 1;
          if (m_good[ch] >= LCK) m_mode[ch] = M_LOCKED;
        end else if (ko) begin
          m_mode[ch] = M_SYNC;
          m_good[ch] = 0;
        end
      end else if (m_mode[ch] == M_LOCKED) begin
        if (ko) m_mode[ch] = M_FAULT;
      end
      if (ed) m_last[ch] = m_n;
    end
    m_prev = v;
    m_n++;
  endfunction

  function automatic logic [2:0] m_lock();
    logic [2:0] r;
    for (int ch = 0; ch < 3; ch++) r[ch] = (m_mode[ch] == M_LOCKED);
    return r;
  endfunction

  function automatic logic [2:0] m_err();
    logic [2:0] r;
    for (int ch = 0; ch < 3; ch++) r[ch] = (m_mode[ch] == M_FAULT);
    return r;
  endfunction

  // ---------------- ideal divider generator with disturbances ----------------
  int         ph[3];
  int         hold[3];
  logic [2:0] dv;

  function automatic void gen_reset();
    for (int ch = 0; ch < 3; ch++) begin
      ph[ch]   = 0;
      hold[ch] = 0;
    end
    dv = 3'b000;
  endfunction

  function automatic void gen_step();
    for (int ch = 0; ch < 3; ch++) begin
      if (hold[ch] > 0) begin
        hold[ch]--;
      end else begin
        ph[ch]++;
        if (ph[ch] >= half_of[ch]) begin
          dv[ch] = ~dv[ch];
          ph[ch] = 0;
        end
      end
    end
  endfunction

  // Apply one cycle of inputs at the falling edge, step the model for the
  // coming rising edge, then compare just after that edge.
  task automatic drive(input bit e, input logic [2:0] v);
    @(negedge clk);
    enb   = e;
    clk10 = v[0];
    clk20 = v[1];
    clk40 = v[2];
    model_step(e, v);
    @(posedge clk);
    #1;
    check("model", {25'd0, all_lock, err, lock}, {25'd0, &m_lock(), m_err(), m_lock()});
  endtask

  task automatic tick(input bit e);
    gen_step();
    drive(e, dv);
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic do_reset(input string name);
    @(negedge clk);
    #2;
    rst   = 1'b0;
    clk10 = 1'b0;
    clk20 = 1'b0;
    clk40 = 1'b0;
    #1;
    check({name, "_lock"},     {29'd0, lock}, 32'd0);
    check({name, "_err"},      {29'd0, err},  32'd0);
    check({name, "_all_lock"}, {31'd0, all_lock}, 32'd0);
    model_reset();
    gen_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Run with ideal dividers and record the first cycle each lock shows up.
  task automatic run_relock(input string name, input bit exact);
    int t10, t40, tall;
    t10 = 0; t40 = 0; tall = 0;
    for (int i = 1; i <= 40; i++) begin
      tick(1'b1);
      if (t40 == 0 && lock[2]) t40 = i;
      if (t10 == 0 && lock[0]) t10 = i;
      if (tall == 0 && all_lock) tall = i;
    end
    if (exact) begin
      check({name, "_t40"},  t40,  6);
      check({name, "_t10"},  t10,  20);
      check({name, "_tall"}, tall, 20);
    end else begin
      check({name, "_t40_le6"},  (t40 > 0 && t40 <= 6), 1);
      check({name, "_t10_le21"}, (t10 > 0 && t10 <= 21), 1);
    end
    check({name, "_lock"},     {29'd0, lock}, 32'd7);
    check({name, "_all_lock"}, {31'd0, all_lock}, 32'd1);
  endtask

  typedef struct {
    bit         e;
    logic [2:0] v;
    logic [2:0] lk;
    logic [2:0] er;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    int nz;
    int errseen, tl;
    logic [2:0] rv;

    model_reset();
    gen_reset();

    // reset state
    #3;
    check("rst_lock", {29'd0, lock}, 32'd0);
    check("rst_err",  {29'd0, err},  32'd0);
    check("rst_all",  {31'd0, all_lock}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // enb low with toggling inputs, then clk40 locks and faults on a held level
    tbl[0]  = '{1'b0, 3'b111, 3'b000, 3'b000};
    tbl[1]  = '{1'b0, 3'b000, 3'b000, 3'b000};
    tbl[2]  = '{1'b0, 3'b101, 3'b000, 3'b000};
    tbl[3]  = '{1'b0, 3'b010, 3'b000, 3'b000};
    tbl[4]  = '{1'b0, 3'b111, 3'b000, 3'b000};
    tbl[5]  = '{1'b0, 3'b000, 3'b000, 3'b000};
    tbl[6]  = '{1'b1, 3'b100, 3'b000, 3'b000};
    tbl[7]  = '{1'b1, 3'b000, 3'b000, 3'b000};
    tbl[8]  = '{1'b1, 3'b100, 3'b000, 3'b000};
    tbl[9]  = '{1'b1, 3'b000, 3'b000, 3'b000};
    tbl[10] = '{1'b1, 3'b100, 3'b000, 3'b000};
    tbl[11] = '{1'b1, 3'b000, 3'b100, 3'b000};
    tbl[12] = '{1'b1, 3'b100, 3'b100, 3'b000};
    tbl[13] = '{1'b1, 3'b100, 3'b000, 3'b100};
    tbl[14] = '{1'b1, 3'b000, 3'b000, 3'b100};
    tbl[15] = '{1'b0, 3'b100, 3'b000, 3'b000};
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].e, tbl[i].v);
      check($sformatf("tbl%0d_lock", i), {29'd0, lock}, {29'd0, tbl[i].lk});
      check($sformatf("tbl%0d_err", i),  {29'd0, err},  {29'd0, tbl[i].er});
      check($sformatf("tbl%0d_all", i),  {31'd0, all_lock}, {31'd0, &tbl[i].lk});
    end

    // nominal lock from reset
    do_reset("nom_rst");
    run_relock("nominal", 1'b1);

    // clk20 stalls for 4 cycles while locked
    hold[1] = 2;
    repeat (6) tick(1'b1);
    check("stall20_err1",  {31'd0, err[1]},  32'd1);
    check("stall20_lock1", {31'd0, lock[1]}, 32'd0);
    check("stall20_lock0", {31'd0, lock[0]}, 32'd1);
    check("stall20_lock2", {31'd0, lock[2]}, 32'd1);
    check("stall20_all",   {31'd0, all_lock}, 32'd0);
    check("stall20_err02", {30'd0, err[2], err[0]}, 32'd0);

    // fault on clk10, then one cycle of enb low, then relock
    hold[0] = 3;
    repeat (8) tick(1'b1);
    check("flt10_err0", {31'd0, err[0]}, 32'd1);
    tick(1'b0);
    check("enb_pulse_err",  {29'd0, err},  32'd0);
    check("enb_pulse_lock", {29'd0, lock}, 32'd0);
    run_relock("enb_relock", 1'b0);

    // one short clk10 half-period while in CHECK
    do_reset("short_rst");
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(1'b1);
      if (m_mode[0] == M_CHECK && ph[0] == 0) found = 1'b1;
    end
    check("short_found", {31'd0, found}, 32'd1);
    ph[0] = 1;
    repeat (3) tick(1'b1);
    check("short_lock0", {31'd0, lock[0]}, 32'd0);
    check("short_err0",  {31'd0, err[0]},  32'd0);
    errseen = 0;
    tl = 0;
    for (int i = 1; i <= 30; i++) begin
      tick(1'b1);
      if (err[0]) errseen++;
      if (tl == 0 && lock[0]) tl = i;
    end
    check("short_relock_t", tl, 20);
    check("short_no_err",   errseen, 0);

    // asynchronous reset mid-lock, relock with nominal timing
    check("prerst_all", {31'd0, all_lock}, 32'd1);
    do_reset("midlock_rst");
    run_relock("rst_relock", 1'b1);

    // enb low for a long stretch with random toggling
    nz = 0;
    for (int i = 0; i < 100; i++) begin
      rv = 3'($urandom);
      dv = rv;
      drive(1'b0, rv);
      if (lock != 3'b000 || err != 3'b000) nz++;
    end
    check("enb_off_quiet", nz, 0);

    // randomized disturbances against the model
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < 3; ch++) begin
        if ($urandom_range(39, 0) == 0) hold[ch] += $urandom_range(3, 1);
        else if ($urandom_range(39, 0) == 0) ph[ch] += 1;
      end
      if ($urandom_range(499, 0) == 0) do_reset("rand_rst");
      tick($urandom_range(99, 0) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
